// File: rtl/mdu_iterative_pkg.sv
// Shared operand width, reset level and MDU operation/state types for the execute stage.
package common;

    localparam int OPERAND_WIDTH = 32;
    localparam logic RESET = 1'b0;
    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    // Encoding matches RISC-V funct3 for the M-extension OP-format instructions
    typedef enum bit [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } mdu_op_type;

    typedef enum bit [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_type;

endpackage

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle, tag passed through,
// result held in DONE until the writeback side accepts it.
module mdu_iterative
    import common::*;
#(
    parameter int XLEN      = OPERAND_WIDTH,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [XLEN-1:0]      in_rs1,
    input  logic [XLEN-1:0]      in_rs2,
    input  logic [TAG_WIDTH-1:0] in_tag,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_result,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 busy
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_type        state;
    logic [CW-1:0]        cnt;
    mdu_op_type           op_q;
    logic                 neg_q;
    logic                 special_q;
    logic [2*XLEN-1:0]    acc;
    logic [XLEN-1:0]      opnd;
    logic [XLEN-1:0]      result_q;
    logic [TAG_WIDTH-1:0] tag_q;

    mdu_op_type           op_in;
    logic                 s1_signed, s2_signed, sign1, sign2;
    logic                 div_in, rem_in, div_zero, overflow, special, neg_in;
    logic [XLEN-1:0]      mag1, mag2, special_res;
    logic [2*XLEN-1:0]    acc_next;
    logic                 div_op_q;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // acc = {partial product high half, remaining multiplier bits}
    function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] a,
                                                   input logic [XLEN-1:0] m);
        logic [XLEN:0] hi;
        hi = {1'b0, a[2*XLEN-1:XLEN]} + (a[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
        return {hi, a[XLEN-1:1]};
    endfunction

    // acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
    function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] a,
                                                   input logic [XLEN-1:0] d);
        logic [XLEN:0] t;
        logic          q;
        t = {a[2*XLEN-1:XLEN], a[XLEN-1]};
        q = 1'b0;
        if (t >= {1'b0, d}) begin
            t = t - {1'b0, d};
            q = 1'b1;
        end
        return {t[XLEN-1:0], a[XLEN-2:0], q};
    endfunction

    function automatic logic [XLEN-1:0] finish_result(input logic [2*XLEN-1:0] a,
                                                      input mdu_op_type op,
                                                      input logic neg);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   val;
        prod = neg ? (~a + 1'b1) : a;
        val  = (op == REM || op == REMU) ? a[2*XLEN-1:XLEN] : a[XLEN-1:0];
        if (op == MUL)
            return prod[XLEN-1:0];
        else if (op == MULH || op == MULHSU || op == MULHU)
            return prod[2*XLEN-1:XLEN];
        else
            return neg ? (~val + 1'b1) : val;
    endfunction

    always_comb begin
        op_in     = mdu_op_type'(in_op);
        s1_signed = (op_in == MULH) || (op_in == MULHSU) || (op_in == DIV) || (op_in == REM);
        s2_signed = (op_in == MULH) || (op_in == DIV) || (op_in == REM);
        sign1     = s1_signed & in_rs1[XLEN-1];
        sign2     = s2_signed & in_rs2[XLEN-1];
        mag1      = magnitude(in_rs1, sign1);
        mag2      = magnitude(in_rs2, sign2);
        div_in    = (op_in == DIV) || (op_in == DIVU) || (op_in == REM) || (op_in == REMU);
        rem_in    = (op_in == REM) || (op_in == REMU);
        div_zero  = div_in && (in_rs2 == '0);
        overflow  = ((op_in == DIV) || (op_in == REM)) && (in_rs1 == MIN_NEG) && (&in_rs2);
        special   = div_zero | overflow;
        neg_in    = rem_in ? sign1 : (sign1 ^ sign2);
        if (div_zero)
            special_res = rem_in ? in_rs1 : '1;
        else
            special_res = rem_in ? '0 : in_rs1;
    end

    assign div_op_q = (op_q == DIV) || (op_q == DIVU) || (op_q == REM) || (op_q == REMU);
    assign acc_next = div_op_q ? div_step(acc, opnd) : mul_step(acc, opnd);

    // Special cases skip iteration but still spend one counted cycle so that
    // every result enters DONE through the same registered path.
    always_ff @(posedge clk or negedge reset) begin
        if (reset == RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= MUL;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            acc       <= '0;
            opnd      <= '0;
            result_q  <= '0;
            tag_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        op_q      <= op_in;
                        tag_q     <= in_tag;
                        neg_q     <= neg_in;
                        special_q <= special;
                        acc       <= {{XLEN{1'b0}}, mag1};
                        opnd      <= mag2;
                        state     <= CALC;
                        if (special) begin
                            result_q <= special_res;
                            cnt      <= CW'(1);
                        end else begin
                            cnt      <= CW'(XLEN);
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) begin
                            if (!special_q)
                                result_q <= finish_result(acc_next, op_q, neg_q);
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (flush || out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state == IDLE);
    assign busy       = (state != IDLE);
    assign out_valid  = (state == DONE);
    assign out_result = result_q;
    assign out_tag    = tag_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed RV32M cases, random ops against a
// 64-bit arithmetic reference, backpressure, flush and mid-operation reset.
module tb_mdu_iterative;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;

    int errors = 0;
    int checks = 0;

    mdu_iterative #(.XLEN(32), .TAG_WIDTH(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] p;
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0: p = $signed({32'b0, a}) * $signed({32'b0, b});
            3'd1: p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            3'd2: p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
            3'd3: p = $signed({32'b0, a}) * $signed({32'b0, b});
            default: p = '0;
        endcase
        case (op)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 32;
    endfunction

    // Offers one op from IDLE; lat counts edges after the accept edge until out_valid (-1 on timeout).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, output logic [31:0] res,
                          output logic [4:0] otag, output int lat);
        res  = '0;
        otag = '0;
        lat  = -1;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = tag;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_rs1   = $urandom;
        in_rs2   = $urandom;
        in_tag   = 5'($urandom);
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                lat  = k;
                res  = out_result;
                otag = out_tag;
                break;
            end
        end
        if (out_ready === 1'b1 && lat > 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            out_result !== 32'h0 || out_tag !== 5'h0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b valid=%b busy=%b result=%h tag=%h, want 1 0 0 0 0",
                     in_ready, out_valid, busy, out_result, out_tag);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ready=%b busy=%b, want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_directed;
        logic [2:0]  ops [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                  3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] as  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                  32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2,
                                  32'd2, 32'd2, 32'd7, 32'd7,
                                  32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                  32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        int          elat [12] = '{32, 32, 32, 32, 32, 32, 32, 32, 1, 1, 1, 1};
        logic [31:0] res;
        logic [4:0]  otag;
        int          lat;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            run_op(ops[i], as[i], bs[i], 5'(i + 3), res, otag, lat);
            checks++;
            if (res !== exp[i]) begin
                errors++;
                $display("FAIL directed_result[%0d] op=%0d: got %h, want %h", i, ops[i], res, exp[i]);
            end
            checks++;
            if (otag !== 5'(i + 3)) begin
                errors++;
                $display("FAIL directed_tag[%0d]: got %0d, want %0d", i, otag, i + 3);
            end
            checks++;
            if (lat != elat[i]) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d, want %0d", i, lat, elat[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [31:0] a, b, res;
        logic [4:0]  tag, otag;
        int          lat;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            tag = 5'($urandom);
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 100));
                4: a = 32'h8000_0000;
                default: ;
            endcase
            run_op(op, a, b, tag, res, otag, lat);
            checks++;
            if (res !== ref_mdu(op, a, b) || otag !== tag || lat != ref_latency(op, a, b)) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got res=%h tag=%0d lat=%0d, want res=%h tag=%0d lat=%0d",
                         i, op, a, b, res, otag, lat, ref_mdu(op, a, b), tag, ref_latency(op, a, b));
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] res;
        logic [4:0]  otag;
        int          lat;
        out_ready = 1'b0;
        run_op(3'd4, 32'hFFFF_FF00, 32'd9, 5'd21, res, otag, lat);
        checks++;
        if (res !== ref_mdu(3'd4, 32'hFFFF_FF00, 32'd9) || lat != 32) begin
            errors++;
            $display("FAIL bp_result: got %h lat=%0d, want %h lat=32",
                     res, lat, ref_mdu(3'd4, 32'hFFFF_FF00, 32'd9));
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== res || out_tag !== 5'd21) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b ready=%b result=%h tag=%0d, want 1 0 %h 21",
                         c, out_valid, in_ready, out_result, out_tag, res);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got valid=%b ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush;
        logic [31:0] res;
        logic [4:0]  otag;
        int          lat;
        logic        seen;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd0; in_rs1 = 32'd1234; in_rs2 = 32'd77; in_tag = 5'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc: got ready=%b valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_result: got out_valid seen=%b, want 0", seen);
        end
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_op = 3'd0; in_rs1 = 32'd5; in_rs2 = 32'd6;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle_accept: got busy=%b ready=%b, want 0 1", busy, in_ready);
        end
        run_op(3'd0, 32'd3, 32'd4, 5'd17, res, otag, lat);
        checks++;
        if (res !== 32'd12 || otag !== 5'd17 || lat != 32) begin
            errors++;
            $display("FAIL flush_next_mul: got res=%0d tag=%0d lat=%0d, want 12 17 32", res, otag, lat);
        end
        out_ready = 1'b0;
        run_op(3'd7, 32'd50, 32'd8, 5'd4, res, otag, lat);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (lat != 32 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_done: got lat=%0d valid=%b ready=%b, want 32 0 1", lat, out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] res;
        logic [4:0]  otag;
        int          lat;
        out_ready = 1'b1;
        run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd30, res, otag, lat);
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd5; in_rs1 = 32'd999; in_rs2 = 32'd7; in_tag = 5'd11;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            out_result !== 32'h0 || out_tag !== 5'h0) begin
            errors++;
            $display("FAIL reset_mid_calc: got ready=%b valid=%b busy=%b result=%h tag=%h, want 1 0 0 0 0",
                     in_ready, out_valid, busy, out_result, out_tag);
        end
        @(negedge clk);
        reset = 1'b1;
        run_op(3'd5, 32'd999, 32'd7, 5'd11, res, otag, lat);
        checks++;
        if (res !== 32'd142 || otag !== 5'd11 || lat != 32) begin
            errors++;
            $display("FAIL reset_then_divu: got res=%0d tag=%0d lat=%0d, want 142 11 32", res, otag, lat);
        end
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
